// File: rtl/sobel_window_ctrl.sv
// Frame sequencer for the Sobel line buffers and 3x3 window registers.
// Tracks pixel column/row, drives the shared shift enable and flags complete in-image windows.
module sobel_window_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             FrameStart,
    input  logic             PixValid,
    output logic             FifoEnable,
    output logic             WinValid,
    output logic [COL_W-1:0] ColCnt,
    output logic [ROW_W-1:0] RowCnt,
    output logic             Busy,
    output logic             FrameDone,
    output logic             FrameAbort
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 32'd1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 32'd1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(32'd2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(32'd2);

    state_t           state_r;
    state_t           state_s;
    logic [COL_W-1:0] col_r;
    logic [COL_W-1:0] col_s;
    logic [ROW_W-1:0] row_r;
    logic [ROW_W-1:0] row_s;
    logic             win_r;
    logic             win_s;
    logic             done_r;
    logic             done_s;
    logic             abort_r;
    logic             abort_s;
    logic             busy_r;
    logic             fifo_en_s;

    // Next-state, counter update and pulse generation.
    always_comb begin
        state_s   = state_r;
        col_s     = col_r;
        row_s     = row_r;
        win_s     = 1'b0;
        done_s    = 1'b0;
        abort_s   = 1'b0;
        fifo_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (FrameStart) begin
                    state_s = ST_RUN;
                    col_s   = '0;
                    row_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A restart wins over a pixel; stale line-buffer rows never
                // produce a window because rows 0 and 1 are never flagged.
                if (FrameStart) begin
                    col_s   = '0;
                    row_s   = '0;
                    abort_s = 1'b1;
                end else if (PixValid) begin
                    fifo_en_s = 1'b1;
                    win_s     = (row_r >= ROW_TWO) && (col_r >= COL_TWO);
                    if (col_r == COL_LAST) begin
                        col_s = '0;
                        if (row_r == ROW_LAST) begin
                            row_s   = '0;
                            state_s = ST_DONE;
                            done_s  = 1'b1;
                        end else begin
                            row_s = row_r + ROW_W'(1'b1);
                        end
                    end else begin
                        col_s = col_r + COL_W'(1'b1);
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                col_s = '0;
                row_s = '0;
                if (FrameStart) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                col_s   = '0;
                row_s   = '0;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            col_r   <= '0;
            row_r   <= '0;
            win_r   <= 1'b0;
            done_r  <= 1'b0;
            abort_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            col_r   <= col_s;
            row_r   <= row_s;
            win_r   <= win_s;
            done_r  <= done_s;
            abort_r <= abort_s;
            busy_r  <= (state_s == ST_RUN);
        end
    end

    assign FifoEnable = fifo_en_s;
    assign WinValid   = win_r;
    assign ColCnt     = col_r;
    assign RowCnt     = row_r;
    assign Busy       = busy_r;
    assign FrameDone  = done_r;
    assign FrameAbort = abort_r;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl on a 4x4 image: vector table,
// directed corner sequences and random stimulus against a pixel-index model.
module tb_sobel_window_ctrl;

    localparam int W = 4;
    localparam int H = 4;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       FrameStart = 1'b0;
    logic       PixValid = 1'b0;
    logic       FifoEnable;
    logic       WinValid;
    logic [1:0] ColCnt;
    logic [1:0] RowCnt;
    logic       Busy;
    logic       FrameDone;
    logic       FrameAbort;

    int tests = 0;
    int fails = 0;
    int win_count = 0;

    // Reference model: mode 0 idle, 1 run, 2 done; position kept as a linear pixel index.
    int m_mode = 0;
    int m_idx  = 0;
    bit e_win, e_done, e_abort;

    typedef struct {
        logic fs;
        logic pv;
        logic e_fe;
        logic e_win;
        int   e_col;
        int   e_row;
        logic e_busy;
        logic e_done;
    } vec_t;
    vec_t tbl [18];

    sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(2), .ROW_W(2)) dut (
        .CLK(CLK), .Reset(Reset), .FrameStart(FrameStart), .PixValid(PixValid),
        .FifoEnable(FifoEnable), .WinValid(WinValid), .ColCnt(ColCnt), .RowCnt(RowCnt),
        .Busy(Busy), .FrameDone(FrameDone), .FrameAbort(FrameAbort)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic rst, input logic fs, input logic pv);
        e_win = 1'b0; e_done = 1'b0; e_abort = 1'b0;
        if (rst) begin
            m_mode = 0; m_idx = 0;
        end else if (m_mode == 0) begin
            if (fs) begin m_mode = 1; m_idx = 0; end
        end else if (m_mode == 1) begin
            if (fs) begin
                m_idx = 0; e_abort = 1'b1;
            end else if (pv) begin
                e_win = (m_idx / W >= 2) && (m_idx % W >= 2);
                m_idx++;
                if (m_idx == W * H) begin m_mode = 2; m_idx = 0; e_done = 1'b1; end
            end
        end else begin
            m_mode = fs ? 1 : 0; m_idx = 0;
        end
    endtask

    // One clock: drive inputs, check the combinational enable, clock, check registered outputs.
    task automatic step(input logic rst, input logic fs, input logic pv, output logic fe_seen);
        Reset = rst; FrameStart = fs; PixValid = pv;
        #1;
        fe_seen = FifoEnable;
        if (!rst) check("fifo_enable", FifoEnable, (m_mode == 1) && pv && !fs);
        @(posedge CLK);
        model_update(rst, fs, pv);
        #1;
        check("col", ColCnt, m_idx % W);
        check("row", RowCnt, m_idx / W);
        check("busy", Busy, m_mode == 1);
        check("win_valid", WinValid, e_win);
        check("frame_done", FrameDone, e_done);
        check("frame_abort", FrameAbort, e_abort);
        if (WinValid === 1'b1) win_count++;
    endtask

    // Optional FrameStart, then feed pixels (back-to-back or every other cycle) until 16 are accepted.
    task automatic run_frame(input bit start, input bit toggle);
        logic fe;
        int acc = 0;
        win_count = 0;
        if (start) step(1'b0, 1'b1, 1'b0, fe);
        for (int c = 0; c < 80 && acc < W * H; c++) begin
            step(1'b0, 1'b0, toggle ? logic'(c % 2 == 0) : 1'b1, fe);
            if (fe === 1'b1) acc++;
        end
        check("frame_accepts", acc, W * H);
        check("frame_wins", win_count, 4);
        check("done_after_last", FrameDone, 1'b1);
        check("busy_in_done", Busy, 1'b0);
    endtask

    initial begin
        logic fe;
        int a;

        tbl[0] = '{fs: 1'b1, pv: 1'b0, e_fe: 1'b0, e_win: 1'b0, e_col: 0, e_row: 0, e_busy: 1'b1, e_done: 1'b0};
        for (int k = 1; k <= 16; k++) begin
            a = k - 1;
            tbl[k].fs     = 1'b0;
            tbl[k].pv     = 1'b1;
            tbl[k].e_fe   = 1'b1;
            tbl[k].e_win  = (a == 10 || a == 11 || a == 14 || a == 15);
            tbl[k].e_col  = (a == 15) ? 0 : (a + 1) % 4;
            tbl[k].e_row  = (a == 15) ? 0 : (a + 1) / 4;
            tbl[k].e_busy = (a != 15);
            tbl[k].e_done = (a == 15);
        end
        tbl[17] = '{fs: 1'b0, pv: 1'b1, e_fe: 1'b0, e_win: 1'b0, e_col: 0, e_row: 0, e_busy: 1'b0, e_done: 1'b0};

        // Two cycles of reset, then reset-state checks.
        step(1'b1, 1'b0, 1'b0, fe);
        step(1'b1, 1'b0, 1'b0, fe);
        check("rst_col", ColCnt, 0);
        check("rst_busy", Busy, 1'b0);

        // Back-to-back frame from the vector table.
        win_count = 0;
        for (int k = 0; k < 18; k++) begin
            step(1'b0, tbl[k].fs, tbl[k].pv, fe);
            check("tbl_fe", fe, tbl[k].e_fe);
            check("tbl_win", WinValid, tbl[k].e_win);
            check("tbl_col", ColCnt, tbl[k].e_col);
            check("tbl_row", RowCnt, tbl[k].e_row);
            check("tbl_busy", Busy, tbl[k].e_busy);
            check("tbl_done", FrameDone, tbl[k].e_done);
        end
        check("tbl_wins", win_count, 4);

        // PixValid toggling every cycle.
        run_frame(1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, fe);

        // PixValid held in IDLE without FrameStart.
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b1, fe);
            check("idle_fe", fe, 1'b0);
            check("idle_col", ColCnt, 0);
            check("idle_row", RowCnt, 0);
            check("idle_busy", Busy, 1'b0);
        end

        // Abort after 7 accepts, then a full frame.
        step(1'b0, 1'b1, 1'b0, fe);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b1, fe);
        check("pre_abort_col", ColCnt, 3);
        check("pre_abort_row", RowCnt, 1);
        step(1'b0, 1'b1, 1'b1, fe);
        check("abort_fe", fe, 1'b0);
        check("abort_pulse", FrameAbort, 1'b1);
        check("abort_col", ColCnt, 0);
        check("abort_row", RowCnt, 0);
        check("abort_busy", Busy, 1'b1);
        run_frame(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, fe);

        // Reset mid-frame at row 2, then a clean frame.
        step(1'b0, 1'b1, 1'b0, fe);
        for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 1'b1, fe);
        check("pre_rst_row", RowCnt, 2);
        step(1'b1, 1'b0, 1'b1, fe);
        check("midrst_busy", Busy, 1'b0);
        check("midrst_col", ColCnt, 0);
        check("midrst_row", RowCnt, 0);
        check("midrst_win", WinValid, 1'b0);
        step(1'b0, 1'b0, 1'b1, fe);
        check("midrst_idle_fe", fe, 1'b0);
        run_frame(1'b1, 1'b0);

        // FrameStart in the DONE cycle chains straight into a second frame.
        check("done_cycle_pulse", FrameDone, 1'b1);
        step(1'b0, 1'b1, 1'b0, fe);
        check("chain_busy", Busy, 1'b1);
        run_frame(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, fe);

        // Random traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            step(logic'($urandom_range(0, 299) == 0), logic'($urandom_range(0, 79) == 0),
                 logic'($urandom_range(0, 3) != 0), fe);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
